null_instruction_control_unit: RTL and testbench
================================================

# null_instruction_control_unit

Registered control-path front end that turns a 12-bit non-ALU ("null") instruction plus the 16-bit switch bank into the 55-bit ALU control word. It also breaks that word back into its named fields. It sits between instruction fetch and the ALU/register-file/memory/stack datapath. It covers special, switch-load, memory and stack instructions; pure ALU instructions are decoded elsewhere.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instruction  in  12  [11:8] opcode, [7:4] field X, [3:0] field Y
- switches  in  16  switch bank value
- control_word  out  55  registered control word
- program_counter_increment  out  1  bit [54]
- alu_op  out  4  bits [53:50]
- alu_a_altern  out  16  bits [49:34]
- alu_b_altern  out  16  bits [33:18]
- alu_a_select  out  4  bits [17:14]
- alu_b_select  out  4  bits [13:10]
- alu_a_source  out  1  bit [9]; 1 = altern, 0 = register
- alu_b_source  out  1  bit [8]
- alu_out_select  out  4  bits [7:4]
- alu_load_src  out  2  bits [3:2]; 00 = none, 01 = ALU, 10 = memory, 11 = stack
- alu_store_to_mem  out  1  bit [1]
- alu_store_to_stk  out  1  bit [0]

## Operation
- Three sub-blocks:
  - Encoder: packs the fields into a word in the bit order above.
  - Decoder: slices the word into fields.
  - Instruction decoder: combinational, produces field values.
- ALU op codes: LEFT = 0x0, IADD = 0x1.
- Base word for every opcode:
  - program_counter_increment = 1.
  - All other bits = 0 unless the opcode sets them below.
- Opcodes 0000 UJMP, 0010 DVGA, 0011 SWCL and reserved 0100–0111:
  - NOOP word, i.e. only bit 54 set (0x40_0000_0000_0000).
- Opcode 0001 LDSW op,r:
  - alu_op = X.
  - alu_a_altern = switches, alu_a_source = 1.
  - alu_b_select = Y, alu_b_source = 0.
  - alu_out_select = Y, alu_load_src = 01.
- Read opcodes RMEM 1000, RMOF 1001, RSTK 1010, RSOF 1011, operands (addr = X, dest = Y):
  - alu_a_select = X, alu_out_select = Y.
  - Both sources = 0.
  - Offset variants (RMOF, RSOF): alu_op = IADD, alu_b_select = Y.
  - Plain variants (RMEM, RSTK): alu_op = LEFT, alu_b_select = 0.
  - alu_load_src = 10 for memory, 11 for stack.
- Write opcodes WMEM 1100, WMOF 1101, WSTK 1110, WSOF 1111, operands (addr = X, src = Y):
  - alu_a_select = Y, alu_out_select = X.
  - alu_load_src = 00.
  - Offset variants: alu_op = IADD, alu_b_select = X.
  - Plain variants: alu_op = LEFT, alu_b_select = 0.
  - Memory writes: alu_store_to_mem = 1.
  - Stack writes: alu_store_to_stk = 1.
- The two store bits are never both 1.
- Neither store bit is 1 while alu_load_src ≠ 00.
- The field outputs always equal the slices of control_word.

## Timing
- control_word register:
  - Loads the decoded word on every rising clk.
  - Latency is 1 cycle from instruction/switches to outputs.
  - There is no handshake and no enable.
- Reset:
  - When reset = 1 at a rising edge, control_word loads the NOOP word (0x40_0000_0000_0000).
  - All field outputs therefore reset to 0, except program_counter_increment = 1.
- Reset asserted mid-stream: the next edge yields NOOP regardless of instruction.
- The switches value is sampled at the same edge as the instruction (no separate latch).
- No internal state besides the 55-bit register.

## Configuration
- Macro `NULL_INSTR_SWITCH_LOAD_EN`:
  - Defined: LDSW is decoded as described in Operation.
  - Undefined: LDSW produces the NOOP word, and switches are ignored (alu_a_altern always 0).

## Test plan
- Reset:
  - Assert reset for 2 cycles with instruction = 0x1A5 -> control_word = 0x40_0000_0000_0000, program_counter_increment = 1, all other fields = 0.
- NOOP opcodes:
  - Apply 0x000, 0x200, 0x300, 0x400 in turn -> each yields the NOOP word one cycle later.
- LDSW (macro defined), switches = 0x1242:
  - Apply 0x105 -> alu_op = 0, alu_b_select = 5, alu_a_altern = 0x1242, alu_a_source = 1, alu_b_source = 0, alu_out_select = 5, alu_load_src = 01, stores = 0.
  - Apply 0x1B7 -> alu_op = 0xB, alu_b_select = 7, alu_out_select = 7.
- Memory reads:
  - 0x801 -> alu_op = 0, alu_a_select = 0, alu_out_select = 1, alu_load_src = 10.
  - 0x901 -> alu_op = 1, alu_b_select = 1, otherwise the same as 0x801.
- Writes:
  - 0xC01 -> alu_a_select = 1, alu_out_select = 0, alu_load_src = 00, alu_store_to_mem = 1.
  - 0xF01 -> alu_op = 1, alu_a_select = 1, alu_b_select = 0, alu_store_to_stk = 1, alu_store_to_mem = 0.
- Stack reads:
  - 0xA01 -> alu_load_src = 11, stores = 0.
  - 0xB01 -> alu_op = 1, alu_b_select = 1.
- Macro undefined:
  - Apply 0x105 -> NOOP word.

Source files
------------

// File: rtl/null_instruction_control_unit_if.sv
// Bus between instruction fetch and the null-instruction control unit.
// The master drives the instruction and switch bank; the slave returns the
// registered control word together with its decoded fields.
interface null_instruction_control_unit_if;
   logic [11:0] instruction;
   logic [15:0] switches;
   logic [54:0] control_word;
   logic        program_counter_increment;
   logic [3:0]  alu_op;
   logic [15:0] alu_a_altern;
   logic [15:0] alu_b_altern;
   logic [3:0]  alu_a_select;
   logic [3:0]  alu_b_select;
   logic        alu_a_source;
   logic        alu_b_source;
   logic [3:0]  alu_out_select;
   logic [1:0]  alu_load_src;
   logic        alu_store_to_mem;
   logic        alu_store_to_stk;

   modport master (
      output instruction,
      output switches,
      input  control_word,
      input  program_counter_increment,
      input  alu_op,
      input  alu_a_altern,
      input  alu_b_altern,
      input  alu_a_select,
      input  alu_b_select,
      input  alu_a_source,
      input  alu_b_source,
      input  alu_out_select,
      input  alu_load_src,
      input  alu_store_to_mem,
      input  alu_store_to_stk
   );

   modport slave (
      input  instruction,
      input  switches,
      output control_word,
      output program_counter_increment,
      output alu_op,
      output alu_a_altern,
      output alu_b_altern,
      output alu_a_select,
      output alu_b_select,
      output alu_a_source,
      output alu_b_source,
      output alu_out_select,
      output alu_load_src,
      output alu_store_to_mem,
      output alu_store_to_stk
   );
endinterface

// File: rtl/null_instruction_control_unit.sv
// Null-instruction control unit: decodes special, switch-load, memory and
// stack instructions into the 55-bit ALU control word, registers it, and
// slices the registered word back into named fields.
// Optional feature macro: NULL_INSTR_SWITCH_LOAD_EN enables LDSW decoding;
// without it LDSW is a NOOP and the switch bank is ignored.
module null_instruction_control_unit (
   input logic                           clk,
   input logic                           reset,
   null_instruction_control_unit_if.slave bus
);

   // Control word layout, most significant field first.
   typedef struct packed {
      logic        pc_inc;
      logic [3:0]  alu_op;
      logic [15:0] a_altern;
      logic [15:0] b_altern;
      logic [3:0]  a_select;
      logic [3:0]  b_select;
      logic        a_source;
      logic        b_source;
      logic [3:0]  out_select;
      logic [1:0]  load_src;
      logic        store_mem;
      logic        store_stk;
   } ctrl_fields_t;

   typedef enum logic [3:0] {
      OpUjmp = 4'b0000,
      OpLdsw = 4'b0001,
      OpDvga = 4'b0010,
      OpSwcl = 4'b0011,
      OpRmem = 4'b1000,
      OpRmof = 4'b1001,
      OpRstk = 4'b1010,
      OpRsof = 4'b1011,
      OpWmem = 4'b1100,
      OpWmof = 4'b1101,
      OpWstk = 4'b1110,
      OpWsof = 4'b1111
   } opcode_e;

   localparam logic [3:0]  AluLeft  = 4'h0;
   localparam logic [3:0]  AluIadd  = 4'h1;

   localparam logic [1:0]  LoadNone = 2'b00;
   localparam logic [1:0]  LoadAlu  = 2'b01;
   localparam logic [1:0]  LoadMem  = 2'b10;
   localparam logic [1:0]  LoadStk  = 2'b11;

   localparam logic [54:0] NoopWord = {1'b1, 54'd0};

   // Encoder: fields to word in the documented bit order.
   function automatic logic [54:0] encode(input ctrl_fields_t f);
      return {f.pc_inc, f.alu_op, f.a_altern, f.b_altern, f.a_select, f.b_select,
              f.a_source, f.b_source, f.out_select, f.load_src, f.store_mem,
              f.store_stk};
   endfunction

   logic [3:0]   opcode;
   logic [3:0]   fld_x;
   logic [3:0]   fld_y;
   logic         is_offset;
   ctrl_fields_t dec;
   logic [54:0]  control_word_d;
   logic [54:0]  control_word_q;

   assign opcode    = bus.instruction[11:8];
   assign fld_x     = bus.instruction[7:4];
   assign fld_y     = bus.instruction[3:0];
   // Offset variants of every memory/stack access have the opcode LSB set.
   assign is_offset = opcode[0];

`ifndef NULL_INSTR_SWITCH_LOAD_EN
   // Switch bank has no consumer when switch-load is compiled out.
   logic unused_switches;
   assign unused_switches = ^bus.switches;
`endif

   // Instruction decoder: NOOP base word, overridden per opcode.
   always_comb begin
      dec        = '0;
      dec.pc_inc = 1'b1;
      unique case (opcode)
         OpLdsw: begin
`ifdef NULL_INSTR_SWITCH_LOAD_EN
            dec.alu_op     = fld_x;
            dec.a_altern   = bus.switches;
            dec.a_source   = 1'b1;
            dec.b_select   = fld_y;
            dec.b_source   = 1'b0;
            dec.out_select = fld_y;
            dec.load_src   = LoadAlu;
`endif
         end
         OpRmem, OpRmof, OpRstk, OpRsof: begin
            // Address in X, destination register in Y.
            dec.a_select   = fld_x;
            dec.out_select = fld_y;
            dec.alu_op     = is_offset ? AluIadd : AluLeft;
            dec.b_select   = is_offset ? fld_y : 4'h0;
            dec.load_src   = (opcode == OpRstk || opcode == OpRsof) ? LoadStk : LoadMem;
         end
         OpWmem, OpWmof, OpWstk, OpWsof: begin
            // Address in X, source register in Y.
            dec.a_select   = fld_y;
            dec.out_select = fld_x;
            dec.load_src   = LoadNone;
            dec.alu_op     = is_offset ? AluIadd : AluLeft;
            dec.b_select   = is_offset ? fld_x : 4'h0;
            dec.store_stk  = (opcode == OpWstk || opcode == OpWsof);
            dec.store_mem  = (opcode == OpWmem || opcode == OpWmof);
         end
         // UJMP, DVGA, SWCL and the reserved opcodes keep the NOOP word.
         default: ;
      endcase
   end

   assign control_word_d = encode(dec);

   // Control word register: loads every cycle, NOOP on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         control_word_q <= NoopWord;
      end else begin
         control_word_q <= control_word_d;
      end
   end

   // Decoder: outputs are pure slices of the registered word.
   assign bus.control_word              = control_word_q;
   assign bus.program_counter_increment = control_word_q[54];
   assign bus.alu_op                    = control_word_q[53:50];
   assign bus.alu_a_altern              = control_word_q[49:34];
   assign bus.alu_b_altern              = control_word_q[33:18];
   assign bus.alu_a_select              = control_word_q[17:14];
   assign bus.alu_b_select              = control_word_q[13:10];
   assign bus.alu_a_source              = control_word_q[9];
   assign bus.alu_b_source              = control_word_q[8];
   assign bus.alu_out_select            = control_word_q[7:4];
   assign bus.alu_load_src              = control_word_q[3:2];
   assign bus.alu_store_to_mem          = control_word_q[1];
   assign bus.alu_store_to_stk          = control_word_q[0];

endmodule

// File: tb/tb_null_instruction_control_unit.sv
// Bench for null_instruction_control_unit: directed vector table, reset and
// latency sequences, then randomized traffic against a reference model.
module tb_null_instruction_control_unit;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   null_instruction_control_unit_if bus_if ();

   null_instruction_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef NULL_INSTR_SWITCH_LOAD_EN
   localparam bit SwEn = 1'b1;
`else
   localparam bit SwEn = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [11:0] instr;
      logic [15:0] sw;
      logic [54:0] exp;
   } vec_t;

   localparam logic [54:0] Noop = 55'h40_0000_0000_0000;

   // Build a word from field values in the documented bit order.
   function automatic logic [54:0] pk(logic pc, logic [3:0] op, logic [15:0] aa,
                                      logic [15:0] ba, logic [3:0] as, logic [3:0] bs,
                                      logic asrc, logic bsrc, logic [3:0] os,
                                      logic [1:0] ld, logic m, logic s);
      return {pc, op, aa, ba, as, bs, asrc, bsrc, os, ld, m, s};
   endfunction

   // Reference model written from the opcode table.
   function automatic logic [54:0] model(logic [11:0] instr, logic [15:0] sw);
      logic [3:0] op, x, y;
      logic [3:0] aop, asel, bsel, osel;
      logic [15:0] aalt;
      logic asrc, m, s;
      logic [1:0] ld;
      bit read, write, offset, stack;
      op = instr[11:8]; x = instr[7:4]; y = instr[3:0];
      aop = 0; asel = 0; bsel = 0; osel = 0; aalt = 0; asrc = 0; m = 0; s = 0; ld = 0;
      read   = (op == 4'h8) || (op == 4'h9) || (op == 4'hA) || (op == 4'hB);
      write  = (op == 4'hC) || (op == 4'hD) || (op == 4'hE) || (op == 4'hF);
      offset = (op == 4'h9) || (op == 4'hB) || (op == 4'hD) || (op == 4'hF);
      stack  = (op == 4'hA) || (op == 4'hB) || (op == 4'hE) || (op == 4'hF);
      if (op == 4'h1 && SwEn) begin
         aop = x; aalt = sw; asrc = 1; bsel = y; osel = y; ld = 2'b01;
      end else if (read) begin
         asel = x; osel = y;
         aop  = offset ? 4'h1 : 4'h0;
         bsel = offset ? y : 4'h0;
         ld   = stack ? 2'b11 : 2'b10;
      end else if (write) begin
         asel = y; osel = x;
         aop  = offset ? 4'h1 : 4'h0;
         bsel = offset ? x : 4'h0;
         m = !stack; s = stack;
      end
      return pk(1'b1, aop, aalt, 16'h0, asel, bsel, asrc, 1'b0, osel, ld, m, s);
   endfunction

   task automatic check(string name, logic [54:0] exp);
      logic [54:0] fields;
      fields = {bus_if.program_counter_increment, bus_if.alu_op, bus_if.alu_a_altern,
                bus_if.alu_b_altern, bus_if.alu_a_select, bus_if.alu_b_select,
                bus_if.alu_a_source, bus_if.alu_b_source, bus_if.alu_out_select,
                bus_if.alu_load_src, bus_if.alu_store_to_mem, bus_if.alu_store_to_stk};
      checks++;
      if (bus_if.control_word !== exp) begin
         errors++;
         $display("FAIL %s control_word got %h expected %h", name, bus_if.control_word, exp);
      end
      checks++;
      if (fields !== exp) begin
         errors++;
         $display("FAIL %s fields got %h expected %h", name, fields, exp);
      end
   endtask

   // Apply inputs on the falling edge, sample 1 ns after the next rising edge.
   task automatic step(logic r, logic [11:0] i, logic [15:0] s);
      @(negedge clk);
      reset = r;
      bus_if.instruction = i;
      bus_if.switches = s;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];
   logic [54:0] ldsw_a, ldsw_b;

   initial begin
      reset = 1'b1;
      bus_if.instruction = 12'h1A5;
      bus_if.switches = 16'h1242;

      // Reset held for two cycles with a non-NOOP instruction present.
      step(1'b1, 12'h1A5, 16'h1242);
      check("reset_cycle1", Noop);
      step(1'b1, 12'h1A5, 16'h1242);
      check("reset_cycle2", Noop);
      checks++;
      if (bus_if.program_counter_increment !== 1'b1 || bus_if.alu_a_altern !== 16'h0) begin
         errors++;
         $display("FAIL reset_fields pc_inc %b altern %h expected 1 and 0000",
                  bus_if.program_counter_increment, bus_if.alu_a_altern);
      end

      ldsw_a = SwEn ? pk(1, 4'h0, 16'h1242, 0, 0, 4'h5, 1, 0, 4'h5, 2'b01, 0, 0) : Noop;
      ldsw_b = SwEn ? pk(1, 4'hB, 16'h1242, 0, 0, 4'h7, 1, 0, 4'h7, 2'b01, 0, 0) : Noop;
      vecs.push_back('{"noop_000", 12'h000, 16'h1242, Noop});
      vecs.push_back('{"noop_200", 12'h200, 16'h1242, Noop});
      vecs.push_back('{"noop_300", 12'h300, 16'h1242, Noop});
      vecs.push_back('{"noop_400", 12'h400, 16'h1242, Noop});
      vecs.push_back('{"noop_7ab", 12'h7AB, 16'hFFFF, Noop});
      vecs.push_back('{"ldsw_105", 12'h105, 16'h1242, ldsw_a});
      vecs.push_back('{"ldsw_1b7", 12'h1B7, 16'h1242, ldsw_b});
      vecs.push_back('{"rmem_801", 12'h801, 16'h1242, pk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0)});
      vecs.push_back('{"rmof_901", 12'h901, 16'h1242, pk(1, 1, 0, 0, 0, 1, 0, 0, 1, 2'b10, 0, 0)});
      vecs.push_back('{"wmem_c01", 12'hC01, 16'h1242, pk(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0)});
      vecs.push_back('{"wsof_f01", 12'hF01, 16'h1242, pk(1, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 1)});
      vecs.push_back('{"rstk_a01", 12'hA01, 16'h1242, pk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 0, 0)});
      vecs.push_back('{"rsof_b01", 12'hB01, 16'h1242, pk(1, 1, 0, 0, 0, 1, 0, 0, 1, 2'b11, 0, 0)});
      vecs.push_back('{"wmof_d34", 12'hD34, 16'h1242, pk(1, 1, 0, 0, 4, 3, 0, 0, 3, 2'b00, 1, 0)});
      vecs.push_back('{"wstk_e34", 12'hE34, 16'h1242, pk(1, 0, 0, 0, 4, 0, 0, 0, 3, 2'b00, 0, 1)});
      vecs.push_back('{"rsof_b9c", 12'hB9C, 16'h0000, pk(1, 1, 0, 0, 9, 12, 0, 0, 12, 2'b11, 0, 0)});

      foreach (vecs[k]) begin
         step(1'b0, vecs[k].instr, vecs[k].sw);
         check(vecs[k].name, vecs[k].exp);
      end

      // One-cycle latency: new input must not show before the next edge.
      step(1'b0, 12'hC01, 16'h0);
      @(negedge clk);
      bus_if.instruction = 12'h801;
      #1;
      check("latency_hold", pk(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0));
      @(posedge clk);
      #1;
      check("latency_update", pk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0));

      // Reset in mid-stream overrides a live instruction, then decode resumes.
      step(1'b1, 12'hF01, 16'h1242);
      check("midstream_reset", Noop);
      step(1'b0, 12'hF01, 16'h1242);
      check("after_reset", pk(1, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 1));

      // Randomized traffic against the reference model plus field invariants.
      for (int n = 0; n < 400; n++) begin
         logic [11:0] ri;
         logic [15:0] rs;
         logic        rr;
         ri = 12'($urandom);
         rs = 16'($urandom);
         rr = ($urandom_range(0, 15) == 0);
         step(rr, ri, rs);
         check($sformatf("rand_%0d_i%h", n, ri), rr ? Noop : model(ri, rs));
         checks++;
         if ((bus_if.alu_store_to_mem && bus_if.alu_store_to_stk) ||
             ((bus_if.alu_store_to_mem || bus_if.alu_store_to_stk) &&
              bus_if.alu_load_src != 2'b00)) begin
            errors++;
            $display("FAIL rand_%0d_store_rule mem %b stk %b load %b expected exclusive",
                     n, bus_if.alu_store_to_mem, bus_if.alu_store_to_stk,
                     bus_if.alu_load_src);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
